// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: data-memory geometry and word/address types.
package cpu_pkg;

    localparam int DM_DATA_W = 16;
    localparam int DM_ADDR_W = 12;

    typedef logic [DM_DATA_W-1:0] dm_word_t;
    typedef logic [DM_ADDR_W-1:0] dm_addr_t;

endpackage

// File: rtl/data_memory.sv
// Single-port synchronous data memory, 4096 x 16, registered write-first read.
module data_memory
    import cpu_pkg::*;
#(
    parameter int DATA_W    = DM_DATA_W,
    parameter int ADDR_W    = DM_ADDR_W,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_DM,
    input  logic [DATA_W-1:0] dataDM,
    input  logic [ADDR_W-1:0] addDM,
    output logic [DATA_W-1:0] outDM
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] INIT_VAL = INIT_ZERO ? '0 : 'x;

    // Power-up contents only; reset leaves the array untouched.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

    always_ff @(posedge clk) begin
        if (rst) begin
            outDM <= '0;
        end else if (we_DM) begin
            mem[addDM] <= dataDM;
            outDM      <= dataDM;
        end else begin
            outDM <= mem[addDM];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;
    import cpu_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     we_DM;
    dm_word_t dataDM;
    dm_addr_t addDM;
    dm_word_t outDM;

    int checks   = 0;
    int failures = 0;

    data_memory dut (
        .clk    (clk),
        .rst    (rst),
        .we_DM  (we_DM),
        .dataDM (dataDM),
        .addDM  (addDM),
        .outDM  (outDM)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic w,
                        input dm_addr_t a, input dm_word_t d);
        rst    = r;
        we_DM  = w;
        addDM  = a;
        dataDM = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input dm_word_t exp);
        checks++;
        assert (outDM === exp) else begin
            failures++;
            $error("FAIL %s: outDM=%h expected=%h", tag, outDM, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        we_DM  = 1'b0;
        addDM  = '0;
        dataDM = '0;
        @(negedge clk);

        // Reset with a write request that must be suppressed.
        step(1, 1, 12'h000, 16'h1234); check("rst_edge1", 16'h0000);
        step(1, 1, 12'h000, 16'h1234); check("rst_edge2", 16'h0000);
        step(0, 0, 12'h000, 16'h0000); check("rst_suppressed", 16'h0000);
        step(0, 0, 12'h123, 16'hFFFF); check("init_zero", 16'h0000);

        // Basic write then read back.
        step(0, 1, 12'h000, 16'h00FE); check("wr0_wf", 16'h00FE);
        step(0, 0, 12'h000, 16'h0000); check("rd0", 16'h00FE);
        #4;                              check("rd0_hold", 16'h00FE);
        step(0, 0, 12'h000, 16'h0000); check("rd0_again", 16'h00FE);

        // Sequential addresses.
        step(0, 1, 12'h001, 16'h00D1); check("wr1_wf", 16'h00D1);
        step(0, 0, 12'h000, 16'h0000); check("seq_rd0", 16'h00FE);
        step(0, 0, 12'h001, 16'h0000); check("seq_rd1", 16'h00D1);

        // Read-during-write returns the new word.
        step(0, 1, 12'h005, 16'hAAAA); check("wr5_a", 16'hAAAA);
        step(0, 0, 12'h005, 16'h0000); check("rd5_a", 16'hAAAA);
        step(0, 1, 12'h005, 16'h5555); check("rdw5", 16'h5555);
        step(0, 0, 12'h005, 16'h0000); check("rd5_b", 16'h5555);

        // Boundary address, no aliasing.
        step(0, 1, 12'hFFF, 16'hBEEF); check("wrfff", 16'hBEEF);
        step(0, 1, 12'h000, 16'hCAFE); check("wr0_cafe", 16'hCAFE);
        step(0, 0, 12'hFFF, 16'h0000); check("rdfff", 16'hBEEF);
        step(0, 0, 12'h000, 16'h0000); check("rd0_cafe", 16'hCAFE);
        step(0, 0, 12'h001, 16'h0000); check("rd1_kept", 16'h00D1);

        // Held write enable rewrites every edge.
        step(0, 1, 12'h020, 16'h1111); check("hold_w1", 16'h1111);
        step(0, 1, 12'h020, 16'h2222); check("hold_w2", 16'h2222);
        step(0, 0, 12'h020, 16'h0000); check("hold_rd", 16'h2222);

        // Mid-operation reset keeps contents.
        step(0, 1, 12'h010, 16'h7777); check("wr10", 16'h7777);
        step(1, 0, 12'h010, 16'h0000); check("mid_rst", 16'h0000);
        step(0, 0, 12'h010, 16'h0000); check("rd10_kept", 16'h7777);
        step(0, 0, 12'h005, 16'h0000); check("rd5_kept", 16'h5555);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
